// File: rtl/model_coil_pkg.sv
// Shared constants, gain record and ADC correction helper for the coil current model.
//   ADC_FRAC_SHIFT : accumulator bits dropped before output scaling
//   OUT_SHIFT      : product bits dropped to land in ADC current units
//   KL_DEFAULT/KI_DEFAULT : default integrator gain and output scale
//   gain_t         : per-channel {kl, ki} pair
//   adc_correct()  : offset-binary to signed conversion with symmetric dead zone
package model_coil_pkg;

  localparam int unsigned ADC_FRAC_SHIFT = 19;
  localparam int unsigned OUT_SHIFT      = 23;
  localparam logic [15:0] KL_DEFAULT     = 16'd57358;
  localparam logic [15:0] KI_DEFAULT     = 16'd42089;

  typedef struct packed {
    logic [15:0] kl;
    logic [15:0] ki;
  } gain_t;

  // Flip the low width-1 bits of a raw sample so mid-scale reads as zero, sign-extend
  // from bit width-1, then squash anything within +/-deadzone to zero.
  function automatic logic signed [31:0] adc_correct(input logic [31:0]  raw,
                                                     input int unsigned width,
                                                     input int unsigned deadzone);
    logic [31:0]        flipped;
    logic signed [31:0] corr;
    logic signed [31:0] dz;
    flipped = (raw & ((32'd1 << width) - 32'd1)) ^ ((32'd1 << (width - 1)) - 32'd1);
    corr    = signed'(flipped << (32 - width)) >>> (32 - width);
    dz      = signed'(deadzone);
    if (corr <= dz && corr >= -dz) begin
      corr = '0;
    end
    return corr;
  endfunction

endpackage

// File: rtl/model_coil_chan.sv
// One coil channel: sample hold registers, arm flag, run-time gains, integrator with
// zero/upper clamp, sticky saturation flag and two-stage output scaling.
//   sample_i/vcap_i/vout_i : corrected sample strobe and values for this channel
//   pwm_i                  : gate signal selecting vcap into the integrator
//   gain_we_i/gain_i       : gain pair write
//   zero_i                 : clear accumulator and saturation, disarm
//   iest_o                 : estimated current, offset-binary ADC units
//   sat_o                  : sticky, accumulator reached ACC_MAX
module model_coil_chan
  import model_coil_pkg::*;
#(
  parameter int unsigned ADC_W   = 12,
  parameter int unsigned ACC_W   = 37,
  parameter logic [63:0] ACC_MAX = 64'h0000_000F_FFFF_FFFF,
  parameter logic [15:0] KL_RST  = KL_DEFAULT,
  parameter logic [15:0] KI_RST  = KI_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_i,
  input  logic [ADC_W-1:0] vcap_i,
  input  logic [ADC_W-1:0] vout_i,
  input  logic             pwm_i,
  input  logic             gain_we_i,
  input  gain_t            gain_i,
  input  logic             zero_i,
  output logic [ADC_W-1:0] iest_o,
  output logic             sat_o
);

  localparam int unsigned DV_W = ADC_W + 1;
  localparam int unsigned DI_W = ADC_W + 18;
  localparam int unsigned AT_W = ACC_W - ADC_FRAC_SHIFT;
  localparam int unsigned P_W  = AT_W + 18;
  localparam logic [ACC_W-1:0] ACC_MAX_C = ACC_MAX[ACC_W-1:0];

  logic [ADC_W-1:0] vcap_h_q, vcap_h_d, vout_h_q, vout_h_d;
  logic             armed_q, armed_d;
  gain_t            gain_q, gain_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;
  logic [P_W-1:0]   p_q, p_d;
  logic [ADC_W-1:0] iest_q, iest_d;

  logic [DV_W-1:0]  vcap_ext, deltav;
  logic [DI_W-1:0]  deltai;
  logic [ACC_W:0]   next_acc;
  logic [AT_W-1:0]  acc_top;
  logic             unused_p;

  // All arithmetic is done on sign-extended unsigned vectors; the low bits of a product
  // of properly extended operands equal the signed product.
  always_comb begin
    vcap_ext = pwm_i ? {vcap_h_q[ADC_W-1], vcap_h_q} : '0;
    deltav   = vcap_ext - {vout_h_q[ADC_W-1], vout_h_q};
    deltai   = {{(DI_W-DV_W){deltav[DV_W-1]}}, deltav} * {{(DI_W-16){1'b0}}, gain_q.kl};
    next_acc = {1'b0, acc_q} + {{(ACC_W+1-DI_W){deltai[DI_W-1]}}, deltai};

    vcap_h_d = vcap_h_q;
    vout_h_d = vout_h_q;
    armed_d  = armed_q;
    acc_d    = acc_q;
    sat_d    = sat_q;
    gain_d   = gain_we_i ? gain_i : gain_q;

    if (sample_i) begin
      vcap_h_d = vcap_i;
      vout_h_d = vout_i;
      armed_d  = 1'b1;
    end

    if (zero_i) begin
      acc_d   = '0;
      armed_d = 1'b0;
      sat_d   = 1'b0;
    end else if (!armed_q) begin
      acc_d = '0;
    end else if (next_acc[ACC_W]) begin
      acc_d = '0;
    end else if (next_acc > {1'b0, ACC_MAX_C}) begin
      acc_d = ACC_MAX_C;
      sat_d = 1'b1;
    end else begin
      acc_d = next_acc[ACC_W-1:0];
    end

    acc_top = acc_q[ACC_W-1:ADC_FRAC_SHIFT];
    p_d     = {{(P_W-AT_W){acc_top[AT_W-1]}}, acc_top} * {{(P_W-16){1'b0}}, gain_q.ki};
    // Inverting the low bits re-centres the result on mid-scale like a raw ADC code.
    iest_d  = p_q[ADC_W+OUT_SHIFT-1:OUT_SHIFT] ^ {1'b0, {(ADC_W-1){1'b1}}};
  end

  assign unused_p = ^{p_q[P_W-1:ADC_W+OUT_SHIFT], p_q[OUT_SHIFT-1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      vcap_h_q <= '0;
      vout_h_q <= '0;
      armed_q  <= 1'b0;
      gain_q   <= '{kl: KL_RST, ki: KI_RST};
      acc_q    <= '0;
      sat_q    <= 1'b0;
      p_q      <= '0;
      iest_q   <= {1'b0, {(ADC_W-1){1'b1}}};
    end else begin
      vcap_h_q <= vcap_h_d;
      vout_h_q <= vout_h_d;
      armed_q  <= armed_d;
      gain_q   <= gain_d;
      acc_q    <= acc_d;
      sat_q    <= sat_d;
      p_q      <= p_d;
      iest_q   <= iest_d;
    end
  end

  assign iest_o = iest_q;
  assign sat_o  = sat_q;

endmodule

// File: rtl/model_coil_mc.sv
// Multi-channel output-inductor current model. Corrects incoming ADC samples once,
// decodes sample and gain-write channel selects, and instantiates one model_coil_chan
// per power stage.
//   adc_valid/adc_ch/vcap/vout : raw sample strobe, channel and values
//   pwm, zero_req              : per-channel gate and clear/disarm
//   cfg_we/cfg_ch/cfg_kl/cfg_ki: per-channel gain write
//   iest                       : channel n at [n*ADC_W +: ADC_W]
//   sat                        : per-channel sticky saturation
module model_coil_mc
  import model_coil_pkg::*;
#(
  parameter int unsigned NCH      = 2,
  parameter int unsigned ADC_W    = 12,
  parameter int unsigned ACC_W    = 37,
  parameter int unsigned DEADZONE = 2,
  parameter logic [63:0] ACC_MAX  = 64'h0000_000F_FFFF_FFFF,
  parameter logic [15:0] KL_RST   = KL_DEFAULT,
  parameter logic [15:0] KI_RST   = KI_DEFAULT,
  localparam int unsigned CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 adc_valid,
  input  logic [CH_W-1:0]      adc_ch,
  input  logic [ADC_W-1:0]     vcap,
  input  logic [ADC_W-1:0]     vout,
  input  logic [NCH-1:0]       pwm,
  input  logic                 cfg_we,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [15:0]          cfg_kl,
  input  logic [15:0]          cfg_ki,
  input  logic [NCH-1:0]       zero_req,
  output logic [NCH*ADC_W-1:0] iest,
  output logic [NCH-1:0]       sat
);

  logic [ADC_W-1:0] vcap_corr, vout_corr;
  gain_t            cfg_gain;

  always_comb begin
    vcap_corr   = ADC_W'(adc_correct(32'(vcap), ADC_W, DEADZONE));
    vout_corr   = ADC_W'(adc_correct(32'(vout), ADC_W, DEADZONE));
    cfg_gain.kl = cfg_kl;
    cfg_gain.ki = cfg_ki;
  end

  // Selects >= NCH match no channel, so out-of-range samples and writes drop out here.
  for (genvar n = 0; n < NCH; n++) begin : g_chan
    model_coil_chan #(
      .ADC_W  (ADC_W),
      .ACC_W  (ACC_W),
      .ACC_MAX(ACC_MAX),
      .KL_RST (KL_RST),
      .KI_RST (KI_RST)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .sample_i (adc_valid && (adc_ch == CH_W'(n))),
      .vcap_i   (vcap_corr),
      .vout_i   (vout_corr),
      .pwm_i    (pwm[n]),
      .gain_we_i(cfg_we && (cfg_ch == CH_W'(n))),
      .gain_i   (cfg_gain),
      .zero_i   (zero_req[n]),
      .iest_o   (iest[n*ADC_W +: ADC_W]),
      .sat_o    (sat[n])
    );
  end

endmodule
